// File: rtl/ipsmacge_ifrgmiirx.sv
// RGMII receive framer: decodes DDR nibbles, strips preamble/SFD, delivers frame bytes
// with sof/eof/err/len framing and tracks false carrier and in-band link status.
module ipsmacge_ifrgmiirx (
   input  logic        rxclk,
   input  logic        rxrst_,
   input  logic [3:0]  idat_h,
   input  logic [3:0]  idat_l,
   input  logic        ictl_h,
   input  logic        ictl_l,
   output logic [7:0]  odat,
   output logic        ovld,
   output logic        osof,
   output logic        oeof,
   output logic        oerr,
   output logic [13:0] olen,
   output logic        ofalse,
   output logic        opreerr,
   output logic        olink,
   output logic [1:0]  ospeed,
   output logic        oduplex
);

   typedef enum logic [1:0] {S_IDLE, S_PREAM, S_DATA, S_DROP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  rx_byte;
   logic        dv, er, is_pre, is_sfd;
   logic [7:0]  held;
   logic        held_vld, sof_pend, err_flag;
   logic [13:0] cnt, cnt_inc;
   logic        vld_nxt, sof_nxt, eof_nxt, err_nxt, false_nxt, preerr_nxt;
   logic        enter_data, status_upd;

   assign rx_byte = {idat_l, idat_h};
   assign dv      = ictl_h;
   assign er      = ictl_h ^ ictl_l;
   assign is_pre  = (rx_byte == 8'h55);
   assign is_sfd  = (rx_byte == 8'hD5);
   assign cnt_inc = (cnt == 14'h3FFF) ? cnt : cnt + 14'd1;

   always_ff @(posedge rxclk or negedge rxrst_) begin
      if (!rxrst_) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (dv) state_nxt = is_pre ? S_PREAM : S_DROP;
         S_PREAM: begin
            if (!dv)         state_nxt = S_IDLE;
            else if (is_sfd) state_nxt = S_DATA;
            else if (!is_pre) state_nxt = S_DROP;
         end
         S_DATA:  if (!dv) state_nxt = S_IDLE;
         S_DROP:  if (!dv) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The held byte is always released one edge after capture: by the next data byte or by dv falling.
   always_comb begin
      vld_nxt    = (state == S_DATA) && held_vld;
      eof_nxt    = vld_nxt && !dv;
      sof_nxt    = vld_nxt && sof_pend;
      err_nxt    = eof_nxt && (err_flag || er);
      enter_data = (state == S_PREAM) && dv && is_sfd;
      false_nxt  = ((state == S_IDLE) || (state == S_PREAM)) && !dv && er && (rx_byte == 8'h0E);
      preerr_nxt = dv && (((state == S_IDLE) && !is_pre) ||
                          ((state == S_PREAM) && !is_pre && !is_sfd));
      status_upd = !dv && !er && (idat_h == idat_l);
   end

   always_ff @(posedge rxclk or negedge rxrst_) begin
      if (!rxrst_) begin
         held     <= 8'h00;
         held_vld <= 1'b0;
         sof_pend <= 1'b0;
         err_flag <= 1'b0;
         cnt      <= 14'd0;
      end else begin
         held_vld <= (state == S_DATA) && dv;
         if ((state == S_DATA) && dv) held <= rx_byte;
         if (enter_data)   sof_pend <= 1'b1;
         else if (vld_nxt) sof_pend <= 1'b0;
         if (enter_data)                    err_flag <= 1'b0;
         else if ((state == S_DATA) && er)  err_flag <= 1'b1;
         if (enter_data)   cnt <= 14'd0;
         else if (vld_nxt) cnt <= cnt_inc;
      end
   end

   always_ff @(posedge rxclk or negedge rxrst_) begin
      if (!rxrst_) begin
         odat    <= 8'h00;
         ovld    <= 1'b0;
         osof    <= 1'b0;
         oeof    <= 1'b0;
         oerr    <= 1'b0;
         olen    <= 14'd0;
         ofalse  <= 1'b0;
         opreerr <= 1'b0;
         olink   <= 1'b0;
         ospeed  <= 2'b00;
         oduplex <= 1'b0;
      end else begin
         ovld    <= vld_nxt;
         osof    <= sof_nxt;
         oeof    <= eof_nxt;
         oerr    <= err_nxt;
         ofalse  <= false_nxt;
         opreerr <= preerr_nxt;
         if (vld_nxt) odat <= held;
         if (eof_nxt) olen <= cnt_inc;
         if (status_upd) begin
            olink   <= rx_byte[0];
            ospeed  <= rx_byte[2:1];
            oduplex <= rx_byte[3];
         end
      end
   end

endmodule

// File: tb/tb_ipsmacge_ifrgmiirx.sv
// Bench for ipsmacge_ifrgmiirx: a stream-level reference schedules expected outputs per
// clock edge; a compare process checks every edge, directed tests pin literal results.
module tb_ipsmacge_ifrgmiirx;

   localparam int MAXC = 4096;

   logic        rxclk = 1'b0;
   logic        rxrst_ = 1'b0;
   logic [3:0]  idat_h = 4'h0, idat_l = 4'h0;
   logic        ictl_h = 1'b0, ictl_l = 1'b0;
   logic [7:0]  odat;
   logic        ovld, osof, oeof, oerr, ofalse, opreerr, olink, oduplex;
   logic [13:0] olen;
   logic [1:0]  ospeed;

   ipsmacge_ifrgmiirx dut (
      .rxclk(rxclk), .rxrst_(rxrst_), .idat_h(idat_h), .idat_l(idat_l),
      .ictl_h(ictl_h), .ictl_l(ictl_l), .odat(odat), .ovld(ovld), .osof(osof),
      .oeof(oeof), .oerr(oerr), .olen(olen), .ofalse(ofalse), .opreerr(opreerr),
      .olink(olink), .ospeed(ospeed), .oduplex(oduplex)
   );

   always #5 rxclk = ~rxclk;

   // expected outputs indexed by rising-edge number
   logic [7:0]  exp_dat   [MAXC];
   logic        exp_vld   [MAXC];
   logic        exp_sof   [MAXC];
   logic        exp_eof   [MAXC];
   logic        exp_err   [MAXC];
   logic [13:0] exp_len   [MAXC];
   logic        exp_false [MAXC];
   logic        exp_pre   [MAXC];
   logic        exp_link  [MAXC];
   logic [1:0]  exp_speed [MAXC];
   logic        exp_dup   [MAXC];

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   // reference stream state
   bit       m_seen_pre, m_in_frame, m_dropping, m_ferr;
   int       m_nbytes;
   logic     m_link, m_dup;
   logic [1:0] m_speed;

   // observations used by the literal pins
   int obs_nvld, obs_nsof, obs_neof, obs_sofeof, obs_nfalse, obs_npre, obs_first_cyc;
   int obs_len, obs_err, obs_first_dat, obs_last_dat;
   int byte_cyc;
   logic [7:0] idle_byte = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_slots(input int from);
      for (int i = from; i < MAXC; i++) begin
         exp_dat[i] = 8'h00; exp_vld[i] = 1'b0; exp_sof[i] = 1'b0; exp_eof[i] = 1'b0;
         exp_err[i] = 1'b0;  exp_len[i] = 14'd0; exp_false[i] = 1'b0; exp_pre[i] = 1'b0;
         exp_link[i] = 1'b0; exp_speed[i] = 2'b00; exp_dup[i] = 1'b0;
      end
   endtask

   // Applies the receive rules to the symbol sampled at edge e.
   task automatic model_step(input int e, input logic rst_ok, input logic dv, input logic er,
                             input logic [7:0] b, input logic [3:0] h, input logic [3:0] l);
      if (e + 1 >= MAXC) return;
      if (!rst_ok) begin
         m_seen_pre = 0; m_in_frame = 0; m_dropping = 0; m_ferr = 0; m_nbytes = 0;
         m_link = 1'b0; m_speed = 2'b00; m_dup = 1'b0;
         clear_slots(e);
         return;
      end
      if (m_in_frame) begin
         m_ferr = m_ferr | er;
         if (dv) begin
            exp_vld[e+1] = 1'b1;
            exp_dat[e+1] = b;
            exp_sof[e+1] = (m_nbytes == 0);
            m_nbytes++;
         end else begin
            if (m_nbytes > 0) begin
               exp_eof[e] = 1'b1;
               exp_err[e] = m_ferr;
               exp_len[e] = (m_nbytes > 16383) ? 14'd16383 : 14'(m_nbytes);
            end
            m_in_frame = 0;
         end
      end else if (m_dropping) begin
         if (!dv) m_dropping = 0;
      end else if (m_seen_pre) begin
         if (dv && b == 8'hD5) begin
            m_seen_pre = 0; m_in_frame = 1; m_nbytes = 0; m_ferr = 0;
         end else if (dv && b != 8'h55) begin
            m_seen_pre = 0; m_dropping = 1; exp_pre[e] = 1'b1;
         end else if (!dv) begin
            m_seen_pre = 0;
            if (er && b == 8'h0E) exp_false[e] = 1'b1;
         end
      end else begin
         if (dv) begin
            if (b == 8'h55) m_seen_pre = 1;
            else begin m_dropping = 1; exp_pre[e] = 1'b1; end
         end else if (er && b == 8'h0E) exp_false[e] = 1'b1;
      end
      if (!dv && !er && h == l) begin
         m_link = b[0]; m_speed = b[2:1]; m_dup = b[3];
      end
      exp_link[e] = m_link; exp_speed[e] = m_speed; exp_dup[e] = m_dup;
   endtask

   task automatic drive_raw(input logic dv, input logic er, input logic [3:0] h, input logic [3:0] l);
      idat_h = h; idat_l = l; ictl_h = dv; ictl_l = dv ^ er;
      model_step(cyc + 1, rxrst_, dv, er, {l, h}, h, l);
      if (!rxrst_ && cyc > 0) begin
         #1;
         chk("rst_ovld", 32'(ovld), 32'd0);
         chk("rst_odat", 32'(odat), 32'd0);
         chk("rst_olen", 32'(olen), 32'd0);
         chk("rst_olink", 32'(olink), 32'd0);
      end
      @(negedge rxclk);
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] b);
      drive_raw(dv, er, b[3:0], b[7:4]);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, idle_byte);
   endtask

   task automatic clear_obs();
      obs_nvld = 0; obs_nsof = 0; obs_neof = 0; obs_sofeof = 0; obs_nfalse = 0; obs_npre = 0;
      obs_first_cyc = -1; obs_len = -1; obs_err = -1; obs_first_dat = -1; obs_last_dat = -1;
   endtask

   task automatic send_frame(input int n, input int err_idx);
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 1; i <= n; i++) begin
         if (i == 1) byte_cyc = cyc;
         drive(1'b1, (i == err_idx), 8'(i));
      end
      idle(3);
   endtask

   // compare process: one check set per rising edge
   initial begin
      forever begin
         @(posedge rxclk);
         #1;
         cyc++;
         if (cyc < MAXC) begin
            chk("ovld", 32'(ovld), 32'(exp_vld[cyc]));
            if (exp_vld[cyc]) chk("odat", 32'(odat), 32'(exp_dat[cyc]));
            chk("osof", 32'(osof), 32'(exp_sof[cyc]));
            chk("oeof", 32'(oeof), 32'(exp_eof[cyc]));
            chk("oerr", 32'(oerr), 32'(exp_err[cyc]));
            if (exp_eof[cyc]) chk("olen", 32'(olen), 32'(exp_len[cyc]));
            chk("ofalse", 32'(ofalse), 32'(exp_false[cyc]));
            chk("opreerr", 32'(opreerr), 32'(exp_pre[cyc]));
            chk("olink", 32'(olink), 32'(exp_link[cyc]));
            chk("ospeed", 32'(ospeed), 32'(exp_speed[cyc]));
            chk("oduplex", 32'(oduplex), 32'(exp_dup[cyc]));
         end
         if (ovld === 1'b1) begin
            if (obs_first_cyc < 0) begin obs_first_cyc = cyc; obs_first_dat = int'(odat); end
            obs_nvld++;
            obs_last_dat = int'(odat);
            if (osof) obs_nsof++;
            if (oeof) begin obs_neof++; obs_len = int'(olen); obs_err = int'(oerr); end
            if (osof && oeof) obs_sofeof++;
         end
         if (ofalse === 1'b1) obs_nfalse++;
         if (opreerr === 1'b1) obs_npre++;
      end
   end

   initial begin
      clear_slots(0);
      clear_obs();
      rxrst_ = 1'b0;
      idle(3);
      rxrst_ = 1'b1;
      idle(4);

      // nominal 64-byte frame
      clear_obs();
      send_frame(64, -1);
      chk("f1_nvld", obs_nvld, 64);
      chk("f1_first", obs_first_dat, 32'h01);
      chk("f1_last", obs_last_dat, 32'h40);
      chk("f1_latency", obs_first_cyc - byte_cyc, 2);
      chk("f1_len", obs_len, 64);
      chk("f1_err", obs_err, 0);
      chk("f1_nsof", obs_nsof, 1);

      // RX_ER on byte 10, then a clean frame
      clear_obs();
      send_frame(64, 10);
      chk("f2_err", obs_err, 1);
      chk("f2_len", obs_len, 64);
      clear_obs();
      send_frame(5, -1);
      chk("f3_err", obs_err, 0);
      chk("f3_len", obs_len, 5);

      // bad preamble, then a good frame
      clear_obs();
      drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'hA5);
      drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'hD5); drive(1'b1, 1'b0, 8'h12);
      idle(3);
      chk("pre_npre", obs_npre, 1);
      chk("pre_nvld", obs_nvld, 0);
      send_frame(8, -1);
      chk("pre_next_nvld", obs_nvld, 8);
      chk("pre_next_len", obs_len, 8);

      // SFD with no preamble
      clear_obs();
      drive(1'b1, 1'b0, 8'hD5); drive(1'b1, 1'b0, 8'h01);
      idle(3);
      chk("sfd_npre", obs_npre, 1);
      chk("sfd_nvld", obs_nvld, 0);

      // false carrier, in-band status, mismatched idle
      clear_obs();
      drive(1'b0, 1'b1, 8'h0E);
      drive(1'b0, 1'b0, 8'hDD);
      idle_byte = 8'hDD;
      idle(2);
      chk("fc_nfalse", obs_nfalse, 1);
      chk("st_link", 32'(olink), 32'd1);
      chk("st_speed", 32'(ospeed), 32'd2);
      chk("st_duplex", 32'(oduplex), 32'd1);
      drive_raw(1'b0, 1'b0, 4'h0, 4'h2);
      idle(1);
      chk("st_hold_link", 32'(olink), 32'd1);
      chk("st_hold_speed", 32'(ospeed), 32'd2);
      drive(1'b0, 1'b1, 8'h0F);
      idle(2);
      chk("fc_other", obs_nfalse, 1);

      // single-byte frame
      clear_obs();
      drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'hD5); drive(1'b1, 1'b0, 8'h77);
      idle(3);
      chk("one_nvld", obs_nvld, 1);
      chk("one_sofeof", obs_sofeof, 1);
      chk("one_len", obs_len, 1);
      chk("one_dat", obs_last_dat, 32'h77);

      // SFD immediately followed by dv=0
      clear_obs();
      drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'hD5);
      idle(3);
      chk("empty_nvld", obs_nvld, 0);

      // reset mid-frame at byte 20, then a fresh frame
      clear_obs();
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 1; i <= 19; i++) drive(1'b1, 1'b0, 8'(i));
      rxrst_ = 1'b0;
      drive(1'b1, 1'b0, 8'd20);
      drive(1'b1, 1'b0, 8'd21);
      rxrst_ = 1'b1;
      for (int i = 22; i <= 64; i++) drive(1'b1, 1'b0, 8'(i));
      idle(3);
      chk("rst_nvld", obs_nvld, 18);
      chk("rst_neof", obs_neof, 0);
      chk("rst_npre", obs_npre, 1);
      clear_obs();
      send_frame(16, -1);
      chk("rst_next_nvld", obs_nvld, 16);
      chk("rst_next_len", obs_len, 16);
      chk("rst_next_first", obs_first_dat, 32'h01);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ipsmacge_ifrgmiirx.md
IPSMACGE_IFRGMIIRX -- requirements
Module: ipsmacge_ifrgmiirx

Interface
REQ-001 The block SHALL have a single clock `rxclk`, input, 1 bit: the RGMII receive clock, with all logic on its rising edge.
REQ-002 The block SHALL have `rxrst_`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have `idat_h`, input, 4 bits: RXD captured at the rising edge, i.e. byte bits [3:0].
REQ-004 The block SHALL have `idat_l`, input, 4 bits: RXD captured at the falling edge, i.e. byte bits [7:4].
REQ-005 The block SHALL have `ictl_h`, input, 1 bit: RX_CTL at the rising edge, i.e. RX_DV.
REQ-006 The block SHALL have `ictl_l`, input, 1 bit: RX_CTL at the falling edge, i.e. RX_DV xor RX_ER.
REQ-007 The block SHALL have `odat`, output, 8 bits: received frame byte, destination address first, preamble and SFD stripped.
REQ-008 The block SHALL have `ovld`, output, 1 bit: `odat` valid.
REQ-009 The block SHALL have `osof`, output, 1 bit: first byte of frame, qualified by `ovld`.
REQ-010 The block SHALL have `oeof`, output, 1 bit: last byte of frame, qualified by `ovld`.
REQ-011 The block SHALL have `oerr`, output, 1 bit: frame contained RX_ER, valid with `oeof`.
REQ-012 The block SHALL have `olen`, output, 14 bits: frame byte count, valid with `oeof`.
REQ-013 The block SHALL have `ofalse`, output, 1 bit: one-cycle false-carrier pulse.
REQ-014 The block SHALL have `opreerr`, output, 1 bit: one-cycle pulse on a bad preamble or SFD.
REQ-015 The block SHALL have `olink`, output, 1 bit: in-band link status.
REQ-016 The block SHALL have `ospeed`, output, 2 bits: in-band speed (00 = 10M, 01 = 100M, 10 = 1G).
REQ-017 The block SHALL have `oduplex`, output, 1 bit: in-band duplex (1 = full).

Function
REQ-018 Per cycle, the block SHALL decode: byte = {`idat_l`, `idat_h`}; dv = `ictl_h`; er = `ictl_h` xor `ictl_l`.
REQ-019 The block SHALL implement state machine states IDLE, PREAM, DATA and DROP, with reset state IDLE.
REQ-020 In IDLE, the block SHALL:
- go to PREAM on dv=1 with byte 0x55;
- go to DROP and pulse `opreerr` on dv=1 with any other byte, including 0xD5 (a preamble byte is required).
REQ-021 In PREAM, the block SHALL:
- stay on dv=1 with byte 0x55;
- go to DATA on dv=1 with byte 0xD5;
- go to DROP and pulse `opreerr` on dv=1 with any other byte;
- return to IDLE with no output on dv=0.
REQ-022 In DATA, each dv=1 byte SHALL be held in a one-byte stage, and the previously held byte SHALL be emitted with `ovld`=1.
REQ-023 The first emitted byte of a frame SHALL carry `osof`=1.
REQ-024 In DATA, on dv=0, the held byte SHALL be emitted with `ovld`=1, `oeof`=1, `oerr` and `olen`, and the state SHALL return to IDLE.
REQ-025 If dv falls in DATA with no byte held (SFD immediately followed by dv=0), nothing SHALL be emitted and the state SHALL return to IDLE.
REQ-026 A single-byte frame SHALL assert `osof` and `oeof` on the same cycle.
REQ-027 Latency SHALL be 2 `rxclk` cycles from a data byte at the inputs to its appearance on `odat`.
REQ-028 All outputs SHALL be registered.
REQ-029 er=1 on any DATA cycle SHALL set a sticky frame-error flag; the flag SHALL be reported on `oerr` with `oeof` and cleared on entry to DATA.
REQ-030 `olen` SHALL count emitted bytes, saturate at 16383 and clear on entry to DATA.
REQ-031 In DROP, the block SHALL ignore input until dv=0, then go to IDLE; no `ovld` SHALL occur in DROP.
REQ-032 In IDLE or PREAM, dv=0 with er=1 and byte 0x0E SHALL pulse `ofalse` for one cycle; other dv=0/er=1 codes SHALL be ignored.
REQ-033 When dv=0, er=0 and `idat_h`==`idat_l`, the block SHALL update `olink`=byte[0], `ospeed`=byte[2:1] and `oduplex`=byte[3]; otherwise those outputs SHALL hold their value.
REQ-034 `ovld`, `osof`, `oeof`, `oerr`, `ofalse` and `opreerr` SHALL be zero on every cycle not listed above.

Reset
REQ-035 While `rxrst_`=0, all outputs SHALL be 0: `odat`=0x00, `olen`=0, `ospeed`=00, `olink`=0, `oduplex`=0.
REQ-036 While `rxrst_`=0, the state SHALL be IDLE and the held byte, error flag and counter SHALL be cleared.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no `oeof`.
REQ-038 After reset release, the block SHALL resynchronise at the next dv=0 cycle; a frame already in progress at release SHALL lead to DROP via REQ-020.

Verification
REQ-039 Stimulus: 7x 0x55, 0xD5, bytes 0x01..0x40, then dv=0. Required response: 64 `ovld` cycles with `odat` 0x01..0x40, `osof` on 0x01, `oeof` on 0x40, `olen`=64, `oerr`=0, and the first `ovld` 2 cycles after byte 0x01.
REQ-040 Stimulus: the same frame with er=1 on byte 10. Required response: `oerr`=1 at `oeof`, `olen`=64; a following clean frame gives `oerr`=0.
REQ-041 Stimulus: 0x55, 0x55, 0xA5 with dv=1. Required response: `opreerr` pulses once, no `ovld` until dv=0, and the next good frame is received normally.
REQ-042 Stimulus: dv=0/er=1 with byte 0x0E, then idle byte 0x0D on both nibbles. Required response: `ofalse` pulses once, then `olink`=1, `ospeed`=10, `oduplex`=1; a mismatched-nibble idle leaves status unchanged.
REQ-043 Stimulus: 0x55, 0xD5, 0x77, dv=0. Required response: one `ovld` with `osof`=`oeof`=1 and `olen`=1.
REQ-044 Stimulus: `rxrst_` pulsed low at byte 20 of a frame. Required response: outputs clear immediately, no `oeof`, the frame remainder is dropped and the next frame is received correctly.
